// File: rtl/output_level_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : output_level_pkg
//  Description : Shared types and helpers for the output level meter:
//                controller state encoding, BCD digit type, dB mantissa LUT.
//  Revision    : 1.0 - initial release
// ============================================================================
package output_level_pkg;

    // Width of the signed dB values carried through the meter
    localparam int DB_W = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LATCH   = 2'd1,
        ST_CONVERT = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    typedef logic [3:0] bcd_digit_t;

    // dB offset for the 3 bits just below the leading one of a peak
    function automatic logic signed [3:0] db_lut(input logic [2:0] m);
        case (m)
            3'd0:    db_lut = -4'sd6;
            3'd1:    db_lut = -4'sd5;
            3'd2:    db_lut = -4'sd4;
            3'd3:    db_lut = -4'sd3;
            3'd4:    db_lut = -4'sd2;
            3'd5:    db_lut = -4'sd2;
            default: db_lut = -4'sd1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_seq_convert.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : bcd_seq_convert
//  Description : Sequential double-dabble, 8-bit binary to 3 BCD digits.
//                The first bit is shifted in at load, so the result is ready
//                8 cycles after start with a one-cycle done pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module bcd_seq_convert
    import output_level_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       busy,
    output logic       done,
    output bcd_digit_t dig2,
    output bcd_digit_t dig1,
    output bcd_digit_t dig0
);

    logic [11:0] bcd_q;
    logic [7:0]  bin_q;
    logic [2:0]  cnt_q;
    logic [11:0] adj_d;

    // Add 3 to every digit that would overflow past 9 after the next shift
    always_comb begin
        adj_d = bcd_q;
        for (int d = 0; d < 3; d++) begin
            if (bcd_q[d*4 +: 4] >= 4'd5) begin
                adj_d[d*4 +: 4] = bcd_q[d*4 +: 4] + 4'd3;
            end
        end
    end

    // Load on start, then shift one binary bit into the BCD register per cycle
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcd_q <= '0;
            bin_q <= '0;
            cnt_q <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                bcd_q <= {11'd0, bin[7]};
                bin_q <= {bin[6:0], 1'b0};
                cnt_q <= 3'd7;
                busy  <= 1'b1;
            end else if (busy) begin
                bcd_q <= (adj_d << 1) | {11'd0, bin_q[7]};
                bin_q <= bin_q << 1;
                cnt_q <= cnt_q - 3'd1;
                if (cnt_q == 3'd1) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign dig2 = bcd_q[11:8];
    assign dig1 = bcd_q[7:4];
    assign dig0 = bcd_q[3:0];

endmodule
`default_nettype wire

// File: rtl/output_level_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : output_level_meter
//  Description : Multi-channel windowed peak meter with dBFS conversion,
//                peak hold / decay, sticky clip flags and a BCD display of
//                the selected channel, refreshed 10 cycles after each window.
//  Revision    : 1.0 - initial release
// ============================================================================
module output_level_meter
    import output_level_pkg::*;
#(
    parameter int WIDTH        = 16,
    parameter int NUM_CH       = 2,
    parameter int WINDOW_LOG2  = 6,
    parameter int HOLD_WINDOWS = 2,
    parameter int DECAY_DB     = 3,
    parameter int FLOOR_DB     = 96
) (
    input  logic                                     clk,
    input  logic                                     reset_n,
    input  logic                                     sample_valid,
    input  logic [NUM_CH*WIDTH-1:0]                  sample,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] ch_sel,
    input  logic                                     clip_clr,
    output bcd_digit_t                               num2,
    output bcd_digit_t                               num1,
    output bcd_digit_t                               num0,
    output logic                                     neg,
    output logic [NUM_CH-1:0]                        clip,
    output logic                                     level_valid
);

    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int HC_W  = (HOLD_WINDOWS > 0) ? $clog2(HOLD_WINDOWS + 1) : 1;
    localparam int IDX_W = $clog2(WIDTH - 1);
    localparam logic signed [DB_W-1:0] FLOOR_NEG = DB_W'(-FLOOR_DB);
    localparam logic signed [DB_W-1:0] DECAY     = DB_W'(DECAY_DB);
    localparam logic [HC_W-1:0]        HOLD_INIT = HC_W'(HOLD_WINDOWS);

    state_t                        state_q;
    logic [CH_W-1:0]               sel_q;
    logic [WINDOW_LOG2-1:0]        win_cnt_q;
    logic                          win_close;
    logic [NUM_CH-1:0][DB_W-1:0]   held_all_d;
    logic [NUM_CH-1:0]             held_sign;
    logic signed [DB_W-1:0]        sel_held_d;
    logic [DB_W-1:0]               sel_mag;
    logic                          sel_neg;
    logic [7:0]                    conv_bin;
    logic                          conv_start;
    logic                          conv_busy;
    logic                          conv_done;
    bcd_digit_t                    conv_d2, conv_d1, conv_d0;

    // The sample that makes the counter wrap is the last one of the window
    assign win_close = sample_valid && (win_cnt_q == '1);

    // Window counter runs on every valid sample regardless of controller state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            win_cnt_q <= '0;
        end else if (sample_valid) begin
            win_cnt_q <= win_cnt_q + 1'b1;
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic signed [WIDTH-1:0] x;
        logic [WIDTH-2:0]        mag, win_max, peak_q, closed_q;
        logic signed [DB_W-1:0]  win_db, held_q, held_d, dec_d;
        logic [HC_W-1:0]         hcnt_q, hcnt_d;
        logic                    clip_q;

        assign x = $signed(sample[c*WIDTH +: WIDTH]);

        // |x|, with the most negative code saturated to full scale
        always_comb begin
            if (!x[WIDTH-1]) begin
                mag = x[WIDTH-2:0];
            end else if (x[WIDTH-2:0] == '0) begin
                mag = '1;
            end else begin
                mag = ~x[WIDTH-2:0] + 1'b1;
            end
        end

        assign win_max = (mag > peak_q) ? mag : peak_q;

        // Running window peak; the closing sample is folded into the closed peak
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                peak_q   <= '0;
                closed_q <= '0;
            end else if (sample_valid) begin
                if (win_close) begin
                    closed_q <= win_max;
                    peak_q   <= '0;
                end else begin
                    peak_q   <= win_max;
                end
            end
        end

        // Closed peak to integer dBFS from leading-one position and 3-bit mantissa
        always_comb begin
            int         p;
            int         idx;
            logic [2:0] m;
            p = 0;
            m = '0;
            for (int i = 0; i < WIDTH - 1; i++) begin
                if (closed_q[i]) p = i;
            end
            for (int k = 0; k < 3; k++) begin
                idx = p - 1 - k;
                if (idx >= 0) m[2-k] = closed_q[IDX_W'(idx)];
            end
            if (closed_q == '0) begin
                win_db = FLOOR_NEG;
            end else begin
                win_db = DB_W'(int'(db_lut(m)) - 6 * (WIDTH - 2 - p));
            end
        end

        // Peak-hold / decay next state for this channel
        always_comb begin
            held_d = held_q;
            hcnt_d = hcnt_q;
            dec_d  = held_q - DECAY;
            if (win_db >= held_q) begin
                held_d = win_db;
                hcnt_d = HOLD_INIT;
            end else if (hcnt_q != '0) begin
                hcnt_d = hcnt_q - 1'b1;
            end else begin
                held_d = (dec_d > win_db) ? dec_d : win_db;
            end
        end

        // Held level commits once per window, in the LATCH cycle
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                held_q <= FLOOR_NEG;
                hcnt_q <= '0;
            end else if (state_q == ST_LATCH) begin
                held_q <= held_d;
                hcnt_q <= hcnt_d;
            end
        end

        // Sticky clip flag; a new full-scale sample beats a simultaneous clear
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                clip_q <= 1'b0;
            end else if (sample_valid && (mag == '1)) begin
                clip_q <= 1'b1;
            end else if (clip_clr) begin
                clip_q <= 1'b0;
            end
        end

        assign clip[c]       = clip_q;
        assign held_all_d[c] = held_d;
        assign held_sign[c]  = held_q[DB_W-1];
    end

    // Channel selection: live ch_sel feeds the converter during LATCH,
    // the latched copy picks the sign shown alongside the digits
    always_comb begin
        sel_held_d = held_all_d[0];
        sel_neg    = held_sign[0];
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_sel == CH_W'(c)) sel_held_d = held_all_d[c];
            if (sel_q  == CH_W'(c)) sel_neg    = held_sign[c];
        end
        sel_mag  = sel_held_d[DB_W-1] ? -sel_held_d : sel_held_d;
        conv_bin = (|sel_mag[DB_W-1:8]) ? 8'hFF : sel_mag[7:0];
    end

    assign conv_start = (state_q == ST_LATCH);

    bcd_seq_convert u_bcd (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (conv_start),
        .bin     (conv_bin),
        .busy    (conv_busy),
        .done    (conv_done),
        .dig2    (conv_d2),
        .dig1    (conv_d1),
        .dig0    (conv_d0)
    );

    // Display controller; a window close always restarts the sequence
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            sel_q       <= '0;
            num2        <= '0;
            num1        <= '0;
            num0        <= '0;
            neg         <= 1'b0;
            level_valid <= 1'b0;
        end else begin
            level_valid <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    state_q <= ST_IDLE;
                end
                ST_LATCH: begin
                    sel_q   <= ch_sel;
                    state_q <= ST_CONVERT;
                end
                ST_CONVERT: begin
                    if (conv_done && !conv_busy) begin
                        num2        <= conv_d2;
                        num1        <= conv_d1;
                        num0        <= conv_d0;
                        neg         <= sel_neg;
                        level_valid <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
            if (win_close) begin
                state_q <= ST_LATCH;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_output_level_meter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_output_level_meter
//  Description : Self-checking bench for output_level_meter. A reference
//                model predicts each display update when the closing sample
//                is driven; the monitor compares it when level_valid fires.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_output_level_meter;

    localparam int WIDTH  = 16;
    localparam int NUM_CH = 2;
    localparam int WIN    = 64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        sample_valid;
    logic [31:0] sample;
    logic [0:0]  ch_sel;
    logic        clip_clr;
    logic [3:0]  num2, num1, num0;
    logic        neg;
    logic [1:0]  clip;
    logic        level_valid;

    always #5 clk = ~clk;

    output_level_meter #(
        .WIDTH        (WIDTH),
        .NUM_CH       (NUM_CH),
        .WINDOW_LOG2  (6),
        .HOLD_WINDOWS (2),
        .DECAY_DB     (3),
        .FLOOR_DB     (96)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .sample       (sample),
        .ch_sel       (ch_sel),
        .clip_clr     (clip_clr),
        .num2         (num2),
        .num1         (num1),
        .num0         (num0),
        .neg          (neg),
        .clip         (clip),
        .level_valid  (level_valid)
    );

    typedef struct {
        logic [11:0] digits;
        logic        neg;
        int          due;
    } exp_t;

    exp_t       sb[$];
    int         n_chk = 0;
    int         n_err = 0;
    int         cyc   = 0;
    int         held[2];
    int         hcnt[2];
    int         pk[2];
    int         wcnt;
    logic [1:0] clip_m;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                     tag, act, act, exp, exp, cyc);
        end
    endtask

    function automatic int tb_abs(input int s);
        if (s == -32768) return 32767;
        return (s < 0) ? -s : s;
    endfunction

    function automatic int tb_db(input int p_in);
        int lut[8] = '{-6, -5, -4, -3, -2, -2, -1, -1};
        int p;
        int m;
        if (p_in == 0) return -96;
        p = 0;
        while ((p_in >> (p + 1)) != 0) p++;
        if (p >= 3) m = (p_in >> (p - 3)) & 7;
        else        m = (p_in << (3 - p)) & 7;
        return lut[m] - 6 * (14 - p);
    endfunction

    task automatic model_reset();
        for (int c = 0; c < 2; c++) begin
            held[c] = -96;
            hcnt[c] = 0;
            pk[c]   = 0;
        end
        wcnt   = 0;
        clip_m = '0;
    endtask

    task automatic close_window();
        exp_t e;
        int   d;
        int   mag;
        for (int c = 0; c < 2; c++) begin
            d = tb_db(pk[c]);
            if (d >= held[c]) begin
                held[c] = d;
                hcnt[c] = 2;
            end else if (hcnt[c] > 0) begin
                hcnt[c]--;
            end else begin
                held[c] = (held[c] - 3 > d) ? held[c] - 3 : d;
            end
            pk[c] = 0;
        end
        wcnt     = 0;
        mag      = (held[ch_sel] < 0) ? -held[ch_sel] : held[ch_sel];
        e.neg    = (held[ch_sel] < 0);
        e.digits = {4'(mag / 100), 4'((mag / 10) % 10), 4'(mag % 10)};
        e.due    = cyc + 10;
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input int s0, input int s1, input bit v, input bit clr);
        int s[2];
        int a;
        s[0]         = s0;
        s[1]         = s1;
        sample_valid = v;
        clip_clr     = clr;
        sample       = {s1[15:0], s0[15:0]};
        for (int c = 0; c < 2; c++) begin
            a = tb_abs(s[c]);
            if (v && a > pk[c]) pk[c] = a;
            if (v && a == 32767) clip_m[c] = 1'b1;
            else if (clr)        clip_m[c] = 1'b0;
        end
        if (v) begin
            wcnt++;
            if (wcnt == WIN) close_window();
        end
        @(posedge clk);
        #1;
        sample_valid = 1'b0;
        clip_clr     = 1'b0;
    endtask

    task automatic set_sel(input int v);
        idle(2);
        ch_sel = v[0:0];
    endtask

    // Scoreboard monitor: each level_valid must match the oldest prediction
    always @(negedge clk) begin
        exp_t e;
        if (reset_n === 1'b1) begin
            if (level_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_level_valid", level_valid, 0);
                end else begin
                    e = sb.pop_front();
                    check("display_digits", {num2, num1, num0}, e.digits);
                    check("display_neg", neg, e.neg);
                    check("update_latency", cyc, e.due);
                end
            end else if (sb.size() > 0 && cyc > sb[0].due) begin
                check("level_valid_missing", level_valid, 1);
                void'(sb.pop_front());
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int r0, r1, nv;
        reset_n      = 1'b0;
        sample_valid = 1'b0;
        sample       = '0;
        ch_sel       = '0;
        clip_clr     = 1'b0;
        model_reset();

        #12;
        check("reset_digits", {num2, num1, num0}, 12'h000);
        check("reset_neg", neg, 0);
        check("reset_clip", clip, 0);
        check("reset_level_valid", level_valid, 0);
        @(posedge clk);
        #2 reset_n = 1'b1;
        idle(1);

        // Silent window after reset
        repeat (WIN) send(0, 0, 1, 0);
        idle(12);

        // Two channels at different levels; selection changes mid-conversion
        repeat (WIN) send(16384, 32767, 1, 0);
        set_sel(1);
        repeat (WIN) send(0, 0, 1, 0);
        idle(12);

        // Clip flag: set, persist, clear, set-beats-clear
        set_sel(0);
        send(-32768, 0, 1, 0);
        check("clip_set", clip, clip_m);
        repeat (WIN - 1) send(0, 0, 1, 0);
        repeat (WIN) send(0, 0, 1, 0);
        check("clip_persist", clip, clip_m);
        send(0, 0, 1, 1);
        check("clip_cleared", clip, clip_m);
        send(0, -32768, 1, 1);
        check("clip_set_wins", clip, clip_m);
        send(0, 0, 0, 1);
        check("clip_clear_idle", clip, clip_m);
        while (wcnt != 0) send(0, 0, 1, 0);
        idle(12);

        // Full scale then silence: hold, decay, floor
        repeat (WIN) send(32767, 0, 1, 0);
        repeat (36) begin
            repeat (WIN) send(0, 0, 1, 0);
        end
        idle(12);

        // Smallest non-zero peak
        send(1, 0, 1, 0);
        repeat (WIN - 1) send(0, 0, 1, 0);
        idle(12);

        // Random windows with gaps in sample_valid
        repeat (3) begin
            set_sel(int'($urandom_range(0, 1)));
            nv = 0;
            while (nv < WIN) begin
                r0 = (int'($urandom_range(0, 65535)) - 32768) >>> $urandom_range(0, 15);
                r1 = (int'($urandom_range(0, 65535)) - 32768) >>> $urandom_range(0, 15);
                if ($urandom_range(0, 3) == 0) begin
                    send(r0, r1, 0, 0);
                end else begin
                    send(r0, r1, 1, 0);
                    nv++;
                end
            end
        end
        idle(12);

        // Reset asserted while the converter is running
        send(0, -32768, 1, 0);
        repeat (WIN - 1) send(100, 0, 1, 0);
        idle(4);
        #3 reset_n = 1'b0;
        #1;
        check("midconv_reset_digits", {num2, num1, num0}, 12'h000);
        check("midconv_reset_neg", neg, 0);
        check("midconv_reset_clip", clip, 0);
        check("midconv_reset_level_valid", level_valid, 0);
        sb.delete();
        model_reset();
        @(posedge clk);
        #2 reset_n = 1'b1;
        idle(1);
        repeat (WIN) send(0, 0, 1, 0);
        idle(15);

        check("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
